// File: rtl/spi_mem_master.sv
// spi_mem_master: SPI SRAM master with a 32-bit command+address header and 1-4 byte data phase.
// SPI_MEM_MASTER_BURST_EN enables multi-byte transfers; without it every request moves one byte.
module spi_mem_master #(
  parameter logic [7:0] RD_CMD   = 8'h03,
  parameter logic [7:0] WR_CMD   = 8'h02,
  parameter int         MISO_DLY = 0,
  parameter int         CS_GAP   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [23:0] req_addr,
  input  logic [1:0]  req_len,
  input  logic [31:0] req_wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        cs_n,
  output logic        mosi,
  input  logic        miso
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] CMD  = 3'd1;
  localparam logic [2:0] ADDR = 3'd2;
  localparam logic [2:0] TURN = 3'd3;
  localparam logic [2:0] DATA = 3'd4;
  localparam logic [2:0] GAP  = 3'd5;
  logic [2:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d, last;
  logic [63:0] sr_q, sr_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  len_q, len_d, len_eff;
  logic        we_q, we_d, ready_q, ready_d, done_q, done_d;
`ifdef SPI_MEM_MASTER_BURST_EN
  assign len_eff = req_len;
`else
  assign len_eff = req_len & 2'b00;
`endif
  // reads hold cs_n one cycle past the last sample, hence the extra count
  assign last = {3'b000, len_q, 3'b111} + {7'd0, ~we_q};
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 8'd1;
    sr_d    = sr_q;
    rdata_d = rdata_q;
    we_d    = we_q;
    len_d   = len_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req_valid && ready_q) begin
          state_d = CMD;
          we_d    = req_we;
          len_d   = len_eff;
          sr_d    = {req_we ? WR_CMD : RD_CMD, req_addr, req_wdata << {2'd3 - len_eff, 3'b000}};
          rdata_d = req_we ? rdata_q : '0;
        end
      end
      CMD: begin
        sr_d = sr_q << 1;
        if (cnt_q == 8'd7) begin
          state_d = ADDR;
          cnt_d   = '0;
        end
      end
      ADDR: begin
        sr_d = sr_q << 1;
        if (cnt_q == 8'd23) begin
          state_d = (!we_q && MISO_DLY > 0) ? TURN : DATA;
          cnt_d   = '0;
        end
      end
      TURN: begin
        if (cnt_q == 8'(MISO_DLY - 1)) begin
          state_d = DATA;
          cnt_d   = '0;
        end
      end
      DATA: begin
        sr_d    = sr_q << 1;
        rdata_d = (!we_q && cnt_q != last) ? {rdata_q[30:0], miso} : rdata_q;
        if (cnt_q == last) begin
          state_d = CS_GAP > 0 ? GAP : IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == 8'(CS_GAP - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = state_d == IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      len_q   <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      len_q   <= len_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end
  assign cs_n      = !(state_q inside {CMD, ADDR, TURN, DATA});
  assign mosi      = (state_q == CMD || state_q == ADDR || (state_q == DATA && we_q)) && sr_q[63];
  assign req_ready = ready_q;
  assign done      = done_q;
  assign rdata     = rdata_q;
endmodule

// File: tb/tb_spi_mem_master.sv
// tb_spi_mem_master: directed bench for spi_mem_master with a bit-level SPI SRAM model.
module tb_spi_mem_master;
`ifdef SPI_MEM_MASTER_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [23:0] req_addr = '0;
  logic [1:0]  req_len = '0;
  logic [31:0] req_wdata = '0;
  logic [31:0] rdata;
  logic        done;
  logic        cs_n;
  logic        mosi;
  logic        miso = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  int          mbit = 0;
  int          last_len = 0;
  int          last_gap = 0;
  int          hi_run = 0;
  int          mosi_err = 0;
  logic [63:0] rx = '0;
  logic [63:0] last_rx = '0;
  logic [31:0] hdr = '0;
  logic [7:0]  mem [0:1023];
  bit          mem_init = 1'b0;

  spi_mem_master dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata), .rdata(rdata),
    .done(done), .cs_n(cs_n), .mosi(mosi), .miso(miso)
  );

  always #5 clk = ~clk;

  // SRAM model: samples mosi on posedge, drives read data right after the 32-bit header
  always @(posedge clk) begin
    int k, nb;
    logic [7:0] b;
    if (!mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
      mem[10'h407] = 8'h77;
      mem[10'h408] = 8'h88;
      mem[10'h409] = 8'h99;
      mem[10'h40a] = 8'haa;
      mem_init = 1'b1;
    end
    if (done) done_cnt++;
    if (cs_n) begin
      if (mbit > 0) begin
        last_len = mbit;
        last_rx = rx;
        if (mbit > 32 && hdr[31:24] == 8'h02) begin
          nb = (mbit - 32) / 8;
          for (k = 0; k < nb; k++) mem[hdr[9:0] + k] = rx[8*(nb-1-k) +: 8];
        end
      end
      if (mosi) mosi_err++;
      mbit = 0;
      hi_run++;
      miso <= 1'b0;
    end else begin
      if (mbit == 0) last_gap = hi_run;
      hi_run = 0;
      if (mbit >= 32 && hdr[31:24] == 8'h03 && mosi) mosi_err++;
      rx = {rx[62:0], mosi};
      if (mbit < 32) hdr = {hdr[30:0], mosi};
      mbit++;
      if (mbit >= 32 && hdr[31:24] == 8'h03) begin
        k = mbit - 32;
        b = mem[hdr[9:0] + k/8];
        miso <= b[7 - k%8];
      end
    end
  end

  task automatic wait_ready();
    for (int i = 0; i < 100 && req_ready !== 1'b1; i++) @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL wait_ready timeout: ready=%b required 1", req_ready);
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300 && done !== 1'b1; i++) @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL wait_done timeout: done=%b required 1", done);
    end
  endtask

  task automatic run_txn(input logic we, input logic [23:0] a, input logic [1:0] l, input logic [31:0] wd);
    @(negedge clk);
    req_we = we; req_addr = a; req_len = l; req_wdata = wd; req_valid = 1'b1;
    wait_ready();
    @(negedge clk);
    req_valid = 1'b0;
    wait_done();
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n got %b want 1", cs_n); end
    checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi got %b want 0", mosi); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", rdata); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", req_ready); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after got %b want 1", req_ready); end
  endtask

  task automatic test_len_read();
    int d0 = done_cnt;
    run_txn(1'b0, 24'h000407, 2'd3, 32'h0);
    checks++;
    if (rdata !== (BURST ? 32'h778899aa : 32'h00000077)) begin
      errors++; $display("FAIL len_read_rdata got %h want %h", rdata, BURST ? 32'h778899aa : 32'h00000077);
    end
    checks++;
    if (last_len != (BURST ? 65 : 41)) begin
      errors++; $display("FAIL len_read_cs_low got %0d want %0d", last_len, BURST ? 65 : 41);
    end
    checks++; if (done_cnt != d0 + 1) begin errors++; $display("FAIL len_read_done got %0d want %0d", done_cnt - d0, 1); end
  endtask

  task automatic test_burst_write();
    int d0 = done_cnt;
    logic [63:0] mask = BURST ? 64'hffffffff_ffffffff : 64'h000000ff_ffffffff;
    logic [63:0] want = BURST ? 64'h02000405_11223344 : 64'h00000002_00040544;
    run_txn(1'b1, 24'h000405, 2'd3, 32'h11223344);
    checks++;
    if ((last_rx & mask) !== want) begin
      errors++; $display("FAIL write_stream got %h want %h", last_rx & mask, want);
    end
    checks++;
    if (last_len != (BURST ? 64 : 40)) begin
      errors++; $display("FAIL write_cs_low got %0d want %0d", last_len, BURST ? 64 : 40);
    end
    checks++; if (done_cnt != d0 + 1) begin errors++; $display("FAIL write_done got %0d want 1", done_cnt - d0); end
    checks++;
    if (rdata !== (BURST ? 32'h778899aa : 32'h00000077)) begin
      errors++; $display("FAIL write_keeps_rdata got %h want %h", rdata, BURST ? 32'h778899aa : 32'h00000077);
    end
  endtask

  task automatic test_burst_read();
    run_txn(1'b0, 24'h000405, 2'd3, 32'h0);
    checks++;
    if (rdata !== (BURST ? 32'h11223344 : 32'h00000044)) begin
      errors++; $display("FAIL burst_read_rdata got %h want %h", rdata, BURST ? 32'h11223344 : 32'h00000044);
    end
    checks++;
    if (last_len != (BURST ? 65 : 41)) begin
      errors++; $display("FAIL burst_read_cs_low got %0d want %0d", last_len, BURST ? 65 : 41);
    end
  endtask

  task automatic test_single_read();
    run_txn(1'b0, 24'h000409, 2'd0, 32'h0);
    checks++; if (rdata !== 32'h00000099) begin errors++; $display("FAIL single_read_rdata got %h want 00000099", rdata); end
    checks++; if (last_len != 41) begin errors++; $display("FAIL single_read_cs_low got %0d want 41", last_len); end
  endtask

  task automatic test_back_to_back();
    int d0 = done_cnt;
    @(negedge clk);
    req_we = 1'b1; req_addr = 24'h000100; req_len = 2'd0; req_wdata = 32'h000000a5; req_valid = 1'b1;
    wait_ready();
    @(negedge clk);
    req_we = 1'b0; req_wdata = 32'h0;
    wait_done();
    checks++; if (rdata !== 32'h00000099) begin errors++; $display("FAIL b2b_rdata_kept got %h want 00000099", rdata); end
    @(negedge clk);
    wait_ready();
    @(negedge clk);
    req_valid = 1'b0;
    wait_done();
    @(negedge clk);
    checks++; if (rdata !== 32'h000000a5) begin errors++; $display("FAIL b2b_rdata got %h want 000000a5", rdata); end
    checks++; if (done_cnt != d0 + 2) begin errors++; $display("FAIL b2b_done_count got %0d want 2", done_cnt - d0); end
    checks++; if (last_gap < 1) begin errors++; $display("FAIL b2b_cs_gap got %0d want >=1", last_gap); end
  endtask

  task automatic test_reset_mid();
    int d0;
    @(negedge clk);
    req_we = 1'b0; req_addr = 24'h000405; req_len = 2'd0; req_valid = 1'b1;
    wait_ready();
    @(negedge clk);
    req_valid = 1'b0;
    repeat (19) @(negedge clk);
    checks++; if (cs_n !== 1'b0) begin errors++; $display("FAIL mid_cs_low got %b want 0", cs_n); end
    d0 = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL mid_rst_cs_n got %b want 1", cs_n); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_rst_done got %b want 0", done); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready got %b want 0", req_ready); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_ready_after got %b want 1", req_ready); end
    repeat (60) @(negedge clk);
    checks++; if (done_cnt != d0) begin errors++; $display("FAIL mid_no_done got %0d want 0", done_cnt - d0); end
    checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL mid_idle_cs_n got %b want 1", cs_n); end
  endtask

  task automatic test_mosi_quiet();
    checks++; if (mosi_err != 0) begin errors++; $display("FAIL mosi_quiet got %0d want 0", mosi_err); end
  endtask

  initial begin
    test_reset();
    test_len_read();
    test_burst_write();
    test_burst_read();
    test_single_read();
    test_back_to_back();
    test_reset_mid();
    test_mosi_quiet();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
